// File: rtl/rd_sequencer.sv
// Streams NUM_WORDS 32-bit words from SDRAM over pipelined Avalon-MM reads and
// reports their modulo-2^32 sum to the HPS PIO and the HEX/LEDR display.
`timescale 1ns/1ps

module rd_sequencer #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          NUM_WORDS       = 1024,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    output logic        done,
    output logic [31:0] tohexled,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [16:0] LAST_WORD = 17'(NUM_WORDS);
    localparam logic [3:0]  OUT_LIMIT = 4'(MAX_OUTSTANDING);

    state_t      state;
    logic        ready_q;
    logic [31:0] sum;
    logic [16:0] issue_cnt;
    logic [16:0] recv_cnt;
    logic [3:0]  outst_cnt;

    logic        accept;
    logic        rsp_valid;
    logic        start;
    logic [16:0] issue_nxt;
    logic [16:0] recv_nxt;
    logic [3:0]  outst_nxt;
    logic [31:0] sum_nxt;

    // Responses only count while a job is running; late data after an abort
    // or after completion is dropped here.
    assign accept    = avm_read && !avm_waitrequest;
    assign rsp_valid = avm_readdatavalid && (state == ISSUE || state == DRAIN);
    assign start     = ready && !ready_q;

    assign issue_nxt = issue_cnt + 17'(accept);
    assign recv_nxt  = recv_cnt + 17'(rsp_valid);
    assign outst_nxt = outst_cnt + 4'(accept) - 4'(rsp_valid);
    assign sum_nxt   = rsp_valid ? sum + avm_readdata : sum;

    // NOTE: every register below uses <= so all of them see the values from
    // before this edge; a blocking = here would leak new values into later lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            done        <= 1'b0;
            tohexled    <= 32'd0;
            avm_read    <= 1'b0;
            avm_address <= BASE_ADDR;
            sum         <= 32'd0;
            issue_cnt   <= 17'd0;
            recv_cnt    <= 17'd0;
            outst_cnt   <= 4'd0;
        end else begin
            ready_q <= ready;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= ISSUE;
                        sum         <= 32'd0;
                        issue_cnt   <= 17'd0;
                        recv_cnt    <= 17'd0;
                        outst_cnt   <= 4'd0;
                        avm_read    <= 1'b1;
                        avm_address <= BASE_ADDR;
                    end
                end

                ISSUE: begin
                    issue_cnt   <= issue_nxt;
                    recv_cnt    <= recv_nxt;
                    outst_cnt   <= outst_nxt;
                    sum         <= sum_nxt;
                    // A stalled request leaves issue_nxt unchanged, so the address holds.
                    avm_address <= BASE_ADDR + {13'd0, issue_nxt, 2'b00};
                    if (issue_nxt == LAST_WORD) begin
                        avm_read <= 1'b0;
                        if (recv_nxt == LAST_WORD) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            tohexled <= sum_nxt;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        avm_read <= (outst_nxt < OUT_LIMIT);
                    end
                end

                DRAIN: begin
                    avm_read  <= 1'b0;
                    recv_cnt  <= recv_nxt;
                    outst_cnt <= outst_nxt;
                    sum       <= sum_nxt;
                    if (recv_nxt == LAST_WORD) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        tohexled <= sum_nxt;
                    end
                end

                DONE: begin
                    avm_read <= 1'b0;
                    if (!ready) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rd_sequencer.md
RD_SEQUENCER -- requirements
Module: rd_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of first word read from SDRAM.
REQ-002 Parameter NUM_WORDS, default 1024: 32-bit words read per job, range 1..65535.
REQ-003 Parameter MAX_OUTSTANDING, default 4: maximum number of issued reads awaiting readdatavalid, range 1..8.
REQ-004 Port clk, input, 1: single clock; all logic rises on clk.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port ready, input, 1: job request level from the HPS PIO.
REQ-007 Port done, output, 1: job complete, driven to the HPS PIO.
REQ-008 Port tohexled, output, 32: job result for the HEX and LEDR display.
REQ-009 Port avm_address, output, 32: Avalon-MM read address, byte-addressed.
REQ-010 Port avm_read, output, 1: Avalon-MM read request.
REQ-011 Port avm_waitrequest, input, 1: slave stall.
REQ-012 Port avm_readdata, input, 32: read data.
REQ-013 Port avm_readdatavalid, input, 1: read data qualifier (pipelined reads).

Function
REQ-014 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE->ISSUE on the first clk where ready=1 and ready was 0 on the previous clk (rising edge); entry clears sum, issue count, receive count, and outstanding count.
REQ-016 ISSUE: avm_read=1 while issue count < NUM_WORDS and outstanding < MAX_OUTSTANDING; avm_address = BASE_ADDR + 4*issue count.
REQ-017 A read is accepted on a clk with avm_read=1 and avm_waitrequest=0; issue count increments only on acceptance.
REQ-018 While avm_waitrequest=1, avm_address and avm_read hold stable.
REQ-019 Outstanding count +1 on acceptance, -1 on readdatavalid; a simultaneous accept and readdatavalid leaves it unchanged.
REQ-020 On each readdatavalid, sum <= sum + avm_readdata modulo 2^32, and receive count increments.
REQ-021 ISSUE->DRAIN when issue count reaches NUM_WORDS; avm_read=0 in DRAIN.
REQ-022 DRAIN->DONE on the clk where receive count reaches NUM_WORDS; tohexled <= final sum on that edge.
REQ-023 DONE: done=1; DONE->IDLE on the first clk with ready=0; done=0 in all other states.
REQ-024 A ready level held high through DONE->IDLE does not start a new job; a new rising edge is required.
REQ-025 Changes on ready during ISSUE or DRAIN are ignored.
REQ-026 A readdatavalid in IDLE or DONE is ignored: no change to sum, counts, or tohexled.
REQ-027 tohexled holds the last job result until the next job completes; it does not change during a job.
REQ-028 Counters are 17 bits wide, so no wrap occurs at NUM_WORDS=65535.

Reset
REQ-029 Reset asserted sets: state=IDLE, done=0, avm_read=0, avm_address=BASE_ADDR, tohexled=0, sum=0, all counters=0, ready history=0.
REQ-030 Reset asserted mid-job aborts the job immediately; reads still in flight at the slave are dropped via REQ-026.
REQ-031 If ready=1 is sampled on the first clk after reset release, it counts as a rising edge and starts a job.

Verification
REQ-032 NUM_WORDS=4, BASE_ADDR=0, memory words 1,2,3,4, no waitrequest, readdatavalid 2 clk after accept, ready pulsed -> addresses 0,4,8,C; done=1; tohexled=32'h0000000A.
REQ-033 avm_waitrequest=1 for 3 clk on the second read -> address 4 and avm_read held for those 3 clk; final sum unchanged versus REQ-032.
REQ-034 MAX_OUTSTANDING=2, readdatavalid latency 10 clk -> outstanding count never exceeds 2; accept and readdatavalid in the same clk leave the count unchanged.
REQ-035 Words FFFFFFFF and 00000002 -> tohexled=32'h00000001 (wrap-around); ready held high after done -> no second job; ready dropped -> done=0 on the next clk.
REQ-036 Reset pulsed after 2 of 4 reads are accepted, then a stray readdatavalid in IDLE -> all outputs at their reset values; tohexled=0; next ready edge gives a correct full-job sum.
